spart_host_ctrl: RTL and testbench



---
 rtl/spart_host_ctrl_pkg.sv | 31 +++
 rtl/spart_host_ctrl_if.sv | 19 +
 rtl/spart_host_ctrl_fifo.sv | 44 ++++
 rtl/spart_host_ctrl.sv | 129 ++++++++++++
 tb/tb_spart_host_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_host_ctrl_pkg.sv
// Shared types and constants for the SPART host controller.
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_WAIT,
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_RD,
    RX_GAP,
    TX_WR,
    TX_GAP
  } state_t;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_DBLO = 2'b10;
  localparam logic [1:0] ADDR_DBHI = 2'b11;

  // Baud divisor for each br_cfg setting.
  function automatic logic [15:0] baud_divisor(input logic [1:0] cfg);
    logic [15:0] div;
    case (cfg)
      2'b00:   div = 16'd651;
      2'b01:   div = 16'd326;
      2'b10:   div = 16'd163;
      default: div = 16'd81;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_host_ctrl_if.sv
// User-side FIFO port bundle of the SPART host controller.
interface spart_host_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       rx_empty;

  modport master (
    output tx_data, tx_push, rx_pop,
    input  tx_full, rx_data, rx_empty
  );

  modport slave (
    input  tx_data, tx_push, rx_pop,
    output tx_full, rx_data, rx_empty
  );
endinterface

// File: rtl/spart_host_ctrl_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers.
module spart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer advance; blocked operations leave their pointer unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spart_host_ctrl.sv
// SPART bus sequencer: baud programming, RX drain into RX FIFO, TX feed from TX FIFO.
module spart_host_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        br_cfg,
  output logic              iocs,
  output logic              iorw,
  output logic [1:0]        ioaddr,
  inout  wire  [7:0]        databus,
  input  logic              rda,
  input  logic              tbr,
  spart_host_ctrl_if.slave  host,
  output logic              cfg_done
);

  state_t      state, state_nxt;
  logic [1:0]  br_cfg_q;
  logic        cfg_pend;
  logic [15:0] div;
  logic [7:0]  wr_byte;
  logic [7:0]  tx_head;
  logic        tx_empty, tx_pop;
  logic        rx_full, rx_push;
  logic        enter_wait;

  assign div        = baud_divisor(br_cfg_q);
  assign enter_wait = (state_nxt == CFG_WAIT) && (state != CFG_WAIT);
  assign databus    = (iocs && !iorw) ? wr_byte : 'z;

  spart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host.tx_push),
    .din   (host.tx_data),
    .full  (host.tx_full),
    .pop   (tx_pop),
    .dout  (tx_head),
    .empty (tx_empty)
  );

  spart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (databus),
    .full  (rx_full),
    .pop   (host.rx_pop),
    .dout  (host.rx_data),
    .empty (host.rx_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CFG_WAIT;
    else        state <= state_nxt;
  end

  // Next state and bus decode from the registered state.
  always_comb begin
    state_nxt = state;
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = ADDR_BUF;
    wr_byte   = '0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    case (state)
      CFG_WAIT: if (tbr) state_nxt = CFG_LO;
      CFG_LO: begin
        iocs      = 1'b1;
        iorw      = 1'b0;
        ioaddr    = ADDR_DBLO;
        wr_byte   = div[7:0];
        state_nxt = CFG_HI;
      end
      CFG_HI: begin
        iocs      = 1'b1;
        iorw      = 1'b0;
        ioaddr    = ADDR_DBHI;
        wr_byte   = div[15:8];
        state_nxt = IDLE;
      end
      IDLE: begin
        if (cfg_pend)              state_nxt = CFG_WAIT;
        else if (rda && !rx_full)  state_nxt = RX_RD;
        else if (tbr && !tx_empty) state_nxt = TX_WR;
      end
      RX_RD: begin
        iocs      = 1'b1;
        rx_push   = 1'b1;
        state_nxt = RX_GAP;
      end
      TX_WR: begin
        iocs      = 1'b1;
        iorw      = 1'b0;
        wr_byte   = tx_head;
        tx_pop    = 1'b1;
        state_nxt = TX_GAP;
      end
      RX_GAP, TX_GAP: state_nxt = IDLE;
      default: state_nxt = CFG_WAIT;
    endcase
  end

  // Baud setting tracking. br_cfg_q captures the setting when leaving CFG_WAIT
  // so both divisor bytes come from one value; any later change (including one
  // during CFG_LO/CFG_HI) then shows up as a mismatch once back outside the
  // configuration states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cfg_q <= br_cfg;
      cfg_pend <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      if (state == CFG_WAIT && tbr) br_cfg_q <= br_cfg;
      if (state == CFG_HI)  cfg_done <= 1'b1;
      else if (enter_wait)  cfg_done <= 1'b0;
      if (enter_wait)
        cfg_pend <= 1'b0;
      else if (!(state inside {CFG_WAIT, CFG_LO, CFG_HI}) && (br_cfg != br_cfg_q))
        cfg_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spart_host_ctrl.sv
// Scoreboard bench for spart_host_ctrl: expected bus accesses and RX bytes are
// queued by the stimulus and consumed by a negedge monitor.
module tb_spart_host_ctrl;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr;
  logic       cfg_done;
  logic [7:0] rd_byte;

  spart_host_ctrl_if hif ();

  spart_host_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .br_cfg   (br_cfg),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .host     (hif),
    .cfg_done (cfg_done)
  );

  // SPART read data model: drives the bus only during a read access.
  assign databus = (iocs && iorw) ? rd_byte : 'z;

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t        bus_exp[$];
  logic [7:0]  rx_exp[$];
  int unsigned n_vec = 0, n_bad = 0;
  int unsigned acc_cnt = 0, cyc = 0, last_acc_cyc = 0, prev_acc_cyc = 0;

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int unsigned target, input string name);
    int unsigned i = 0;
    while (acc_cnt < target && i < 300) begin
      tick;
      i++;
    end
    check(name, (acc_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_cfg(input logic v, input string name);
    int unsigned i = 0;
    while (cfg_done !== v && i < 300) begin
      tick;
      i++;
    end
    check(name, cfg_done, v);
  endtask

  task automatic push_tx(input logic [7:0] b);
    hif.tx_data = b;
    hif.tx_push = 1'b1;
    tick;
    hif.tx_push = 1'b0;
  endtask

  function automatic acc_t mk(input logic rw, input logic [1:0] a, input logic [7:0] d);
    acc_t e;
    e.rw = rw; e.addr = a; e.data = d;
    return e;
  endfunction

  initial begin
    fork
      // Cycle counter.
      forever begin
        @(posedge clk);
        cyc++;
      end
      // Monitor: every iocs pulse and every accepted rx_pop is checked.
      forever begin
        acc_t e;
        @(negedge clk);
        if (rst_n) begin
          if (iocs) begin
            acc_cnt++;
            prev_acc_cyc = last_acc_cyc;
            last_acc_cyc = cyc;
            if (bus_exp.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL unexpected_access: got rw=%0d addr=%0d data=0x%0h, required no access",
                       iorw, ioaddr, databus);
            end else begin
              e = bus_exp.pop_front();
              check("bus_rw", iorw, e.rw);
              check("bus_addr", ioaddr, e.addr);
              if (!e.rw) check("bus_data", databus, e.data);
            end
          end
          if (hif.rx_pop && !hif.rx_empty) begin
            if (rx_exp.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL unexpected_rx: got 0x%0h, required empty FIFO", hif.rx_data);
            end else begin
              check("rx_data", hif.rx_data, rx_exp.pop_front());
            end
          end
        end
      end
      // Stimulus.
      begin
        int unsigned base, c0;
        rst_n = 1'b0; br_cfg = 2'b00; tbr = 1'b1; rda = 1'b0; rd_byte = 8'h00;
        hif.tx_data = 8'h00; hif.tx_push = 1'b0; hif.rx_pop = 1'b0;
        tick; tick;
        check("rst_iocs", iocs, 0);
        check("rst_iorw", iorw, 1);
        check("rst_ioaddr", ioaddr, 0);
        check("rst_tx_full", hif.tx_full, 0);
        check("rst_rx_empty", hif.rx_empty, 1);
        check("rst_cfg_done", cfg_done, 0);

        // 1: initial divisor programming for br_cfg=00 (651 = 0x028B).
        bus_exp.push_back(mk(1'b0, ADDR_DBLO, 8'h8B));
        bus_exp.push_back(mk(1'b0, ADDR_DBHI, 8'h02));
        @(negedge clk) rst_n = 1'b1;
        wait_cfg(1'b1, "cfg_done_rise");
        check("cfg_done_lat", cyc, last_acc_cyc + 1);
        check("cfg_acc_cnt", acc_cnt, 2);
        repeat (10) tick;
        check("cfg_drain", bus_exp.size(), 0);

        // 2: br_cfg 00->11 (81 = 0x0051) with a TX byte waiting.
        base = acc_cnt;
        bus_exp.push_back(mk(1'b0, ADDR_DBLO, 8'h51));
        bus_exp.push_back(mk(1'b0, ADDR_DBHI, 8'h00));
        bus_exp.push_back(mk(1'b0, ADDR_BUF,  8'h33));
        br_cfg = 2'b11;
        push_tx(8'h33);
        wait_cfg(1'b0, "cfg_done_fall");
        wait_cfg(1'b1, "cfg_done_rerise");
        wait_acc(base + 3, "recfg_wait");
        check("recfg_drain", bus_exp.size(), 0);

        // 3: TX held off by tbr=0, then three writes in order.
        tbr = 1'b0;
        base = acc_cnt;
        push_tx(8'hA5); push_tx(8'h5A); push_tx(8'h3C);
        repeat (8) tick;
        check("tbr_low_hold", acc_cnt, base);
        bus_exp.push_back(mk(1'b0, ADDR_BUF, 8'hA5));
        bus_exp.push_back(mk(1'b0, ADDR_BUF, 8'h5A));
        bus_exp.push_back(mk(1'b0, ADDR_BUF, 8'h3C));
        tbr = 1'b1;
        wait_acc(base + 3, "tx3_wait");
        check("tx_spacing", last_acc_cyc - prev_acc_cyc, 3);

        // TX latency: push at N -> TX_WR at N+2.
        repeat (4) tick;
        base = acc_cnt;
        bus_exp.push_back(mk(1'b0, ADDR_BUF, 8'h11));
        c0 = cyc;
        push_tx(8'h11);
        wait_acc(base + 1, "tx_lat_wait");
        check("tx_latency", last_acc_cyc, c0 + 2);

        // 4: single RX read of 0x7E.
        repeat (4) tick;
        base = acc_cnt;
        bus_exp.push_back(mk(1'b1, ADDR_BUF, 8'h00));
        rx_exp.push_back(8'h7E);
        rd_byte = 8'h7E; rda = 1'b1; c0 = cyc;
        wait_acc(base + 1, "rx_wait");
        rda = 1'b0;
        check("rx_latency", last_acc_cyc, c0 + 1);
        check("rx_not_empty", hif.rx_empty, 0);
        hif.rx_pop = 1'b1;
        tick;
        hif.rx_pop = 1'b0;
        check("rx_empty_after_pop", hif.rx_empty, 1);

        // 5: RX wins over TX when both are ready in the same cycle.
        tbr = 1'b0;
        push_tx(8'h44);
        base = acc_cnt;
        bus_exp.push_back(mk(1'b1, ADDR_BUF, 8'h00));
        bus_exp.push_back(mk(1'b0, ADDR_BUF, 8'h44));
        rx_exp.push_back(8'h99);
        rd_byte = 8'h99; rda = 1'b1; tbr = 1'b1;
        wait_acc(base + 1, "prio_rx_wait");
        rda = 1'b0;
        wait_acc(base + 2, "prio_tx_wait");
        check("prio_spacing", last_acc_cyc - prev_acc_cyc, 3);
        hif.rx_pop = 1'b1;
        tick;
        hif.rx_pop = 1'b0;

        // 6a: TX FIFO overflow, 9th byte dropped.
        tbr = 1'b0;
        for (int i = 0; i < 9; i++) begin
          push_tx(8'h80 + 8'(i));
          if (i == 6) check("tx_full_at7", hif.tx_full, 0);
          if (i == 7) check("tx_full_at8", hif.tx_full, 1);
        end
        check("tx_full_after9", hif.tx_full, 1);
        base = acc_cnt;
        for (int i = 0; i < 8; i++) bus_exp.push_back(mk(1'b0, ADDR_BUF, 8'h80 + 8'(i)));
        tbr = 1'b1;
        wait_acc(base + 8, "tx8_wait");
        repeat (6) tick;
        check("tx_full_drained", hif.tx_full, 0);
        check("tx8_drain", bus_exp.size(), 0);

        // 6b: RX FIFO fills; rda ignored until one pop frees a slot.
        base = acc_cnt;
        for (int i = 0; i < 8; i++) begin
          bus_exp.push_back(mk(1'b1, ADDR_BUF, 8'h00));
          rx_exp.push_back(8'hC0 + 8'(i));
        end
        rd_byte = 8'hC0; rda = 1'b1;
        for (int i = 0; i < 8; i++) begin
          wait_acc(base + i + 1, "rx_fill_wait");
          rd_byte = 8'hC1 + 8'(i);
        end
        repeat (10) tick;
        check("rx_full_hold", acc_cnt, base + 8);
        bus_exp.push_back(mk(1'b1, ADDR_BUF, 8'h00));
        rx_exp.push_back(8'hC8);
        hif.rx_pop = 1'b1;
        tick;
        hif.rx_pop = 1'b0;
        wait_acc(base + 9, "rx_refill_wait");
        rda = 1'b0;
        hif.rx_pop = 1'b1;
        repeat (8) tick;
        hif.rx_pop = 1'b0;
        check("rx_empty_final", hif.rx_empty, 1);
        check("rx_exp_drain", rx_exp.size(), 0);

        // Reset during TX_WR: iocs drops at once, divisor for br_cfg=01 (0x0146).
        repeat (4) tick;
        push_tx(8'h55);
        tick;
        check("txwr_live", iocs, 1);
        #1 rst_n = 1'b0;
        #1 check("iocs_async_drop", iocs, 0);
        br_cfg = 2'b01;
        tick;
        check("rst2_cfg_done", cfg_done, 0);
        check("rst2_rx_empty", hif.rx_empty, 1);
        bus_exp.push_back(mk(1'b0, ADDR_DBLO, 8'h46));
        bus_exp.push_back(mk(1'b0, ADDR_DBHI, 8'h01));
        @(negedge clk) rst_n = 1'b1;
        wait_cfg(1'b1, "rst2_cfg_rise");
        repeat (10) tick;
        check("rst2_drain", bus_exp.size(), 0);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
